// File: rtl/sram_responder_if.sv
// sram_responder_if: address and strobe side of the asynchronous 16-bit SRAM bus.
// The bidirectional data bus stays a plain inout port on the responder so that
// tristate resolution happens on an ordinary net.
interface sram_responder_if #(
  parameter int ADDR_W = 18
);
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_CE_N;
  logic              SRAM_OE_N;
  logic              SRAM_WE_N;
  logic              SRAM_UB_N;
  logic              SRAM_LB_N;

  // Initiator side (controller / testbench)
  modport master (
    output SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N
  );

  // Responder side
  modport slave (
    input SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N
  );
endinterface

// File: rtl/sram_responder.sv
// sram_responder: on-chip stand-in for the external asynchronous 16-bit SRAM.
// All bus inputs pass a two-flop synchroniser; reads come from a byte-lane
// word array through a registered output, writes commit when the write pulse
// ends. Statistics outputs (WR_COUNT, RD_COUNT, ERR) are built only when the
// macro SRAM_RESP_STATS_EN is defined; otherwise they are tied to 0.
module sram_responder #(
  parameter int ADDR_W = 18,
  parameter int MEM_AW = 10
) (
  input  logic            CLOCK_50,
  input  logic            RESET,
  sram_responder_if.slave sram,
  inout  wire  [15:0]     SRAM_DQ,
  output logic [15:0]     WR_COUNT,
  output logic [15:0]     RD_COUNT,
  output logic            ERR
);
  localparam int MEM_WORDS = 1 << MEM_AW;
  // Strobe vector order: {ce_n, oe_n, we_n, ub_n, lb_n}; all-ones is bus idle.
  localparam logic [4:0] STRB_IDLE = 5'b11111;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_COMMIT} state_t;

  logic [4:0]        strb_meta_reg, strb_sync_reg;
  logic [MEM_AW-1:0] addr_meta_reg, addr_sync_reg;
  logic [15:0]       dq_meta_reg, dq_sync_reg;
  state_t            state_reg, state_next;
  logic [MEM_AW-1:0] hold_addr_reg;
  logic [15:0]       hold_data_reg;
  logic [1:0]        hold_lane_reg;
  logic [1:0]        drv_reg;

  logic       ce_n_sync, oe_n_sync, we_n_sync;
  logic [1:0] lane_sync;   // active-high lane enables, [1] = upper byte
  logic       wr_sync, rd_sync, commit_fire, bypass;

  assign {ce_n_sync, oe_n_sync, we_n_sync} = strb_sync_reg[4:2];
  assign lane_sync   = ~strb_sync_reg[1:0];
  assign wr_sync     = !ce_n_sync && !we_n_sync;
  assign rd_sync     = !ce_n_sync && we_n_sync && !oe_n_sync;
  // The held write lands in the array on the edge that enters COMMIT.
  assign commit_fire = (state_reg == ST_WRITE) && (state_next == ST_COMMIT);
  assign bypass      = commit_fire && (hold_addr_reg == addr_sync_reg);

  // Address bits above MEM_AW alias and are deliberately not synchronised.
  if (ADDR_W > MEM_AW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^sram.SRAM_ADDR[ADDR_W-1:MEM_AW];
  end

  // Two-flop synchroniser for strobes, address and data; reset loads bus idle.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      strb_meta_reg <= STRB_IDLE;
      strb_sync_reg <= STRB_IDLE;
      addr_meta_reg <= '0;
      addr_sync_reg <= '0;
      dq_meta_reg   <= '0;
      dq_sync_reg   <= '0;
    end else begin
      strb_meta_reg <= {sram.SRAM_CE_N, sram.SRAM_OE_N, sram.SRAM_WE_N,
                        sram.SRAM_UB_N, sram.SRAM_LB_N};
      strb_sync_reg <= strb_meta_reg;
      addr_meta_reg <= sram.SRAM_ADDR[MEM_AW-1:0];
      addr_sync_reg <= addr_meta_reg;
      dq_meta_reg   <= SRAM_DQ;
      dq_sync_reg   <= dq_meta_reg;
    end
  end

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next state from the synchronised strobes; write wins over read.
  always_comb begin
    state_next = ST_IDLE;
    if (state_reg == ST_WRITE && !wr_sync) state_next = ST_COMMIT;
    else if (wr_sync)                      state_next = ST_WRITE;
    else if (rd_sync)                      state_next = ST_READ;
  end

  // Hold registers track the write pulse; the last capture is what commits.
  always_ff @(posedge CLOCK_50) begin
    if (state_next == ST_WRITE) begin
      hold_addr_reg <= addr_sync_reg;
      hold_data_reg <= dq_sync_reg;
      hold_lane_reg <= lane_sync;
    end
  end

  // Lane drive enables: only while reading, only for lanes enabled at sync.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) drv_reg <= 2'b00;
    else       drv_reg <= (state_next == ST_READ) ? lane_sync : 2'b00;
  end

  // One byte-wide array, registered read port and tristate driver per lane.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [7:0] mem_reg [0:MEM_WORDS-1];
    logic [7:0] q_reg;

    // Array write on commit for this lane only.
    always_ff @(posedge CLOCK_50) begin
      if (commit_fire && hold_lane_reg[gi])
        mem_reg[hold_addr_reg] <= hold_data_reg[gi*8 +: 8];
    end

    // Registered read every cycle; committing data is forwarded on a match.
    always_ff @(posedge CLOCK_50) begin
      if (bypass && hold_lane_reg[gi]) q_reg <= hold_data_reg[gi*8 +: 8];
      else                             q_reg <= mem_reg[addr_sync_reg];
    end

    assign SRAM_DQ[gi*8 +: 8] = drv_reg[gi] ? q_reg : 8'bz;
  end

`ifdef SRAM_RESP_STATS_EN
  logic [15:0] wr_count_reg, rd_count_reg;
  logic        err_reg;

  // Saturating write/read counters and sticky null-write error.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      wr_count_reg <= '0;
      rd_count_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (commit_fire) begin
        if (hold_lane_reg == 2'b00)        err_reg      <= 1'b1;
        else if (wr_count_reg != 16'hFFFF) wr_count_reg <= wr_count_reg + 16'd1;
      end
      if (state_next == ST_READ && state_reg != ST_READ && rd_count_reg != 16'hFFFF)
        rd_count_reg <= rd_count_reg + 16'd1;
    end
  end

  assign WR_COUNT = wr_count_reg;
  assign RD_COUNT = rd_count_reg;
  assign ERR      = err_reg;
`else
  assign WR_COUNT = 16'h0000;
  assign RD_COUNT = 16'h0000;
  assign ERR      = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed test-plan cases followed by random bus traffic,
// checked every cycle against a pin-history model of the responder. The data
// bus carries a pull-up so an undriven lane reads as 8'hFF.
module tb_sram_responder;
  localparam int ADDR_W = 18;
  localparam int MEM_AW = 10;
  localparam int WORDS  = 1 << MEM_AW;
`ifdef SRAM_RESP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic              ce, oe, we, ub, lb;
    logic [MEM_AW-1:0] addr;
    logic [15:0]       data;
  } pins_t;

  logic        clock_50 = 1'b0;
  logic        reset;
  wire  [15:0] sram_dq;
  logic [15:0] wr_count, rd_count;
  logic        err;
  logic        tb_drive;
  logic [15:0] tb_data;

  int n_tests = 0;
  int n_fail  = 0;

  sram_responder_if #(.ADDR_W(ADDR_W)) bus ();

  assign sram_dq = tb_drive ? tb_data : 16'bz;
  pullup (sram_dq);

  always #10 clock_50 = ~clock_50;

  sram_responder #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW)) dut (
    .CLOCK_50 (clock_50),
    .RESET    (reset),
    .sram     (bus),
    .SRAM_DQ  (sram_dq),
    .WR_COUNT (wr_count),
    .RD_COUNT (rd_count),
    .ERR      (err)
  );

  // ---------------- reference model ----------------
  // Output after edge k depends on pins sampled at edges k-2 (h[2]) and k-3 (h[3]).
  pins_t       h [0:3];
  pins_t       cur;
  logic [7:0]  mm [0:1][0:WORDS-1];
  bit          mk [0:1][0:WORDS-1];
  logic [1:0]  m_drv = 2'b00;
  logic [MEM_AW-1:0] m_addr = '0;
  logic [15:0] m_wr = 0, m_rd = 0;
  logic        m_err = 0;
  bit          m_in_read = 0, m_ready = 0, rd_now;
  logic [1:0]  lanes;

  function automatic pins_t idle_pins();
    pins_t p;
    p = '0;
    p.ce = 1'b1; p.oe = 1'b1; p.we = 1'b1; p.ub = 1'b1; p.lb = 1'b1;
    return p;
  endfunction
  function automatic bit is_wr(input pins_t p);
    return !p.ce && !p.we;
  endfunction
  function automatic bit is_rd(input pins_t p);
    return !p.ce && p.we && !p.oe;
  endfunction

  always @(posedge clock_50) begin
    cur.ce = bus.SRAM_CE_N; cur.oe = bus.SRAM_OE_N; cur.we = bus.SRAM_WE_N;
    cur.ub = bus.SRAM_UB_N; cur.lb = bus.SRAM_LB_N;
    cur.addr = bus.SRAM_ADDR[MEM_AW-1:0];
    cur.data = tb_drive ? tb_data : 16'hFFFF;
    for (int i = 3; i > 0; i--) h[i] = h[i-1];
    h[0] = cur;
    if (reset) begin
      h[0] = idle_pins(); h[1] = idle_pins(); h[2] = idle_pins();
      m_drv = 2'b00; m_wr = 0; m_rd = 0; m_err = 0; m_in_read = 0;
    end else begin
      // A write pulse seen at k-3 that has ended at k-2 commits now.
      if (is_wr(h[3]) && !is_wr(h[2])) begin
        lanes = ~{h[3].ub, h[3].lb};
        if (lanes == 2'b00) m_err = 1'b1;
        else begin
          for (int l = 0; l < 2; l++) begin
            if (lanes[l]) begin
              mm[l][h[3].addr] = h[3].data[l*8 +: 8];
              mk[l][h[3].addr] = 1'b1;
            end
          end
          if (m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
        end
      end
      // A read is served unless the cycle just before was still a write (commit slot).
      rd_now = is_rd(h[2]) && !is_wr(h[3]);
      if (rd_now && !m_in_read && m_rd != 16'hFFFF) m_rd = m_rd + 16'd1;
      m_in_read = rd_now;
      m_drv  = rd_now ? ~{h[2].ub, h[2].lb} : 2'b00;
      m_addr = h[2].addr;
    end
    m_ready = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic [15:0] exp_dq, mask;
  always @(negedge clock_50) begin
    if (m_ready) begin
      exp_dq = 16'hFFFF;
      mask   = 16'h0000;
      for (int l = 0; l < 2; l++) begin
        if (tb_drive) begin
          exp_dq[l*8 +: 8] = tb_data[l*8 +: 8];
          mask[l*8 +: 8]   = 8'hFF;
        end else if (m_drv[l]) begin
          if (mk[l][m_addr]) begin
            exp_dq[l*8 +: 8] = mm[l][m_addr];
            mask[l*8 +: 8]   = 8'hFF;
          end
        end else begin
          mask[l*8 +: 8] = 8'hFF;
        end
      end
      if (mask != 16'h0000) check("dq", 32'(sram_dq & mask), 32'(exp_dq & mask));
      check("wr_count", 32'(wr_count), 32'(STATS ? m_wr : 16'h0));
      check("rd_count", 32'(rd_count), 32'(STATS ? m_rd : 16'h0));
      check("err", 32'(err), 32'(STATS ? m_err : 1'b0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock_50);
    #1;
  endtask

  task automatic set_idle();
    bus.SRAM_CE_N = 1'b1; bus.SRAM_OE_N = 1'b1; bus.SRAM_WE_N = 1'b1;
    bus.SRAM_UB_N = 1'b1; bus.SRAM_LB_N = 1'b1;
    tb_drive = 1'b0;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                          input logic ub_n, input logic lb_n, input int len);
    tick();
    bus.SRAM_ADDR = a; tb_data = d; tb_drive = 1'b1;
    bus.SRAM_UB_N = ub_n; bus.SRAM_LB_N = lb_n;
    bus.SRAM_OE_N = 1'b1; bus.SRAM_CE_N = 1'b0; bus.SRAM_WE_N = 1'b0;
    repeat (len) tick();
    set_idle();
  endtask

  task automatic do_read(input logic [17:0] a, input logic [17:0] a2,
                         input logic ub_n, input logic lb_n, input int len);
    tick();
    bus.SRAM_ADDR = a; bus.SRAM_UB_N = ub_n; bus.SRAM_LB_N = lb_n;
    bus.SRAM_CE_N = 1'b0; bus.SRAM_OE_N = 1'b0;
    repeat (len) tick();
    bus.SRAM_ADDR = a2;
    repeat (len) tick();
    set_idle();
    repeat (3) tick();
  endtask

  // Read and pin the bus value three clocks after OE falls to a literal.
  task automatic read_check(input string name, input logic [17:0] a,
                            input logic ub_n, input logic lb_n, input logic [15:0] exp);
    tick();
    bus.SRAM_ADDR = a; bus.SRAM_UB_N = ub_n; bus.SRAM_LB_N = lb_n;
    bus.SRAM_CE_N = 1'b0; bus.SRAM_OE_N = 1'b0;
    repeat (3) @(posedge clock_50);
    @(negedge clock_50);
    check(name, 32'(sram_dq), 32'(exp));
    tick();
    set_idle();
    repeat (3) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] ra, ra2;
    int          sel;
    logic        ub_n, lb_n;

    reset = 1'b1; tb_data = 16'h0; bus.SRAM_ADDR = '0;
    set_idle();
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
    @(negedge clock_50);
    check("reset_wr", 32'(wr_count), 32'h0);
    check("reset_rd", 32'(rd_count), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_dq_z", 32'(sram_dq), 32'hFFFF);

    // Write then read.
    do_write(18'd5, 16'hBEEF, 1'b0, 1'b0, 2);
    repeat (3) tick();
    read_check("rd_beef", 18'd5, 1'b0, 1'b0, 16'hBEEF);
    check("wr_after_beef", 32'(wr_count), STATS ? 32'd1 : 32'd0);
    check("rd_after_beef", 32'(rd_count), STATS ? 32'd1 : 32'd0);

    // Byte-lane write.
    do_write(18'd7, 16'h1234, 1'b0, 1'b0, 2);
    do_write(18'd7, 16'hAB00, 1'b0, 1'b1, 3);
    read_check("rd_lane_merge", 18'd7, 1'b0, 1'b0, 16'hAB34);
    read_check("rd_lower_only", 18'd7, 1'b1, 1'b0, 16'hFF34);

    // Aliasing and write-immediately-read.
    do_write(18'd3, 16'h1111, 1'b0, 1'b0, 2);
    repeat (3) tick();
    do_write(18'h00403, 16'h00FF, 1'b0, 1'b0, 2);
    read_check("rd_alias_bypass", 18'd3, 1'b0, 1'b0, 16'h00FF);

    // Write wins over read.
    do_write(18'd9, 16'hA5A5, 1'b0, 1'b0, 2);
    repeat (3) tick();
    tick();
    bus.SRAM_ADDR = 18'd9; tb_data = 16'h5A5A; tb_drive = 1'b1;
    bus.SRAM_UB_N = 1'b0; bus.SRAM_LB_N = 1'b0;
    bus.SRAM_CE_N = 1'b0; bus.SRAM_OE_N = 1'b0; bus.SRAM_WE_N = 1'b0;
    repeat (4) begin
      @(negedge clock_50);
      check("write_wins_bus", 32'(sram_dq), 32'h5A5A);
      tick();
    end
    set_idle();
    repeat (3) tick();
    read_check("rd_after_wins", 18'd9, 1'b0, 1'b0, 16'h5A5A);

    // Null write: both lanes off.
    do_write(18'd12, 16'hC0DE, 1'b1, 1'b1, 2);
    repeat (4) tick();
    @(negedge clock_50);
    check("null_err", 32'(err), STATS ? 32'd1 : 32'd0);
    check("null_wr", 32'(wr_count), STATS ? 32'd7 : 32'd0);

    // Reset in the middle of a write pulse.
    do_write(18'd20, 16'h1357, 1'b0, 1'b0, 2);
    repeat (3) tick();
    tick();
    bus.SRAM_ADDR = 18'd20; tb_data = 16'h7777; tb_drive = 1'b1;
    bus.SRAM_UB_N = 1'b0; bus.SRAM_LB_N = 1'b0;
    bus.SRAM_CE_N = 1'b0; bus.SRAM_WE_N = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    set_idle();
    tick();
    reset = 1'b0;
    repeat (4) tick();
    @(negedge clock_50);
    check("rst_wr", 32'(wr_count), 32'h0);
    check("rst_rd", 32'(rd_count), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_dq_z", 32'(sram_dq), 32'hFFFF);
    read_check("rd_no_commit", 18'd20, 1'b0, 1'b0, 16'h1357);

    // Random traffic over a small address pool with random aliasing bits.
    for (int t = 0; t < 200; t++) begin
      ra  = (18'($urandom_range(0, 255)) << MEM_AW) | 18'($urandom_range(0, 15));
      ra2 = (18'($urandom_range(0, 255)) << MEM_AW) | 18'($urandom_range(0, 15));
      sel = $urandom_range(0, 9);
      ub_n = (sel == 0 || sel == 1);
      lb_n = (sel == 0 || sel == 2);
      if ($urandom_range(0, 1) == 1) begin
        do_write(ra, 16'($urandom), ub_n, lb_n, $urandom_range(2, 4));
        if ($urandom_range(0, 2) == 0) repeat (3) tick();
      end else begin
        do_read(ra, ($urandom_range(0, 1) == 1) ? ra2 : ra, ub_n, lb_n,
                $urandom_range(1, 4));
      end
    end

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
